// File: rtl/tick_rr_scheduler.sv
// tick_rr_scheduler
// Shares one programmable period-tick timer between N_CH requesters.
// Requesters join and leave the rotation with a one-cycle start/stop toggle.
// Each tick is granted to the next active requester in round-robin order.
// The grant is held until the granted requester acknowledges it.
// A tick that arrives while a grant is still outstanding is dropped and recorded in 'overrun'.
// Optional ack watchdog: define TICK_RR_SCHED_TIMEOUT_EN to enable it.

module tick_rr_scheduler #(
    parameter int N_CH        = 4,
    parameter int CNT_MAX     = 104260,
    parameter int CW          = 25,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_CH-1:0]           start_stop_i,
    input  logic                      period_load_i,
    input  logic [CW-1:0]             period_val_i,
    input  logic [N_CH-1:0]           ack_i,
    input  logic                      ovr_clr_i,
    output logic [N_CH-1:0]           grant_o,
    output logic [$clog2(N_CH)-1:0]   grant_id_o,
    output logic [N_CH-1:0]           active_o,
    output logic                      overrun_o,
    output logic [N_CH-1:0]           timeout_err_o
);

    localparam int IDW = $clog2(N_CH);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    // Reject out-of-range configurations at elaboration time.
    if (N_CH < 2 || N_CH > 8 || ACK_TIMEOUT < 1) begin : g_badConfig
        $error("tick_rr_scheduler: N_CH must be 2..8 and ACK_TIMEOUT must be >= 1");
    end

    state_t           state_q;
    logic [N_CH-1:0]  active_q, active_d;
    logic [CW-1:0]    period_q, period_d;
    logic [CW-1:0]    count_q, count_d;
    logic [N_CH-1:0]  grant_q;
    logic [IDW-1:0]   grantId_q;
    logic [IDW-1:0]   lastId_q;
    logic             overrun_q;

    logic             tick;
    logic [IDW-1:0]   selId;
    logic [IDW-1:0]   candId;
    logic             selFound;
    logic             ackHit;
    logic             grantDrop;
    logic             ackExpired;

    // The timer only advances while somebody participates.
    // The tick marks the last count of each period.
    assign tick      = (active_q != '0) && (count_q == period_q);
    assign ackHit    = ack_i[grantId_q];
    assign grantDrop = start_stop_i[grantId_q];

    // Next-state for the participation mask, the period register and the tick counter.
    always_comb begin
        active_d = active_q ^ start_stop_i;

        period_d = period_q;
        if (period_load_i && (active_q == '0)) begin
            period_d = (period_val_i == '0) ? CW'(1) : period_val_i;
        end

        if (active_q == '0) begin
            count_d = '0;
        end else if (tick) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // Round-robin pick: the first active channel strictly after the last granted one.
    // The search uses the mask as it stands before any toggle in this cycle.
    always_comb begin
        selId    = lastId_q;
        selFound = 1'b0;
        candId   = '0;
        for (int i = 1; i <= N_CH; i++) begin
            candId = IDW'((int'(lastId_q) + i) % N_CH);
            if (!selFound && active_q[candId]) begin
                selId    = candId;
                selFound = 1'b1;
            end
        end
    end

    // Participation mask, period register and tick counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= '0;
            period_q <= CW'(CNT_MAX);
            count_q  <= '0;
        end else begin
            active_q <= active_d;
            period_q <= period_d;
            count_q  <= count_d;
        end
    end

    // Grant FSM: issue on tick from IDLE, then hold until ack, deactivation or watchdog expiry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            grantId_q <= '0;
            lastId_q  <= IDW'(N_CH - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        grant_q   <= {{(N_CH-1){1'b0}}, 1'b1} << selId;
                        grantId_q <= selId;
                        lastId_q  <= selId;
                        state_q   <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ackHit || grantDrop || ackExpired) begin
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    // Sticky overrun.
    // A tick that lands while a grant is outstanding wins over a clear in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overrun_q <= 1'b0;
        end else if (tick && (state_q == WAIT_ACK)) begin
            overrun_q <= 1'b1;
        end else if (ovr_clr_i) begin
            overrun_q <= 1'b0;
        end
    end

`ifdef TICK_RR_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic [TW-1:0]   waitCnt_q;
    logic [N_CH-1:0] timeoutErr_q;

    assign ackExpired = (waitCnt_q == TW'(ACK_TIMEOUT));

    // Ack watchdog.
    // The counter sits at zero while idle, so it counts cycles since the grant was asserted.
    always_ff @(posedge clk_i) begin
        if (rst_i || (state_q == IDLE)) begin
            waitCnt_q <= '0;
        end else if (!ackExpired) begin
            waitCnt_q <= waitCnt_q + TW'(1);
        end
    end

    // Sticky per-channel timeout flags.
    // A flag is raised only when the watchdog is what ends the grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timeoutErr_q <= '0;
        end else if ((state_q == WAIT_ACK) && !ackHit && !grantDrop && ackExpired) begin
            timeoutErr_q <= timeoutErr_q | grant_q;
        end
    end

    assign timeout_err_o = timeoutErr_q;
`else
    assign ackExpired    = 1'b0;
    assign timeout_err_o = '0;
`endif

    assign grant_o    = grant_q;
    assign grant_id_o = grantId_q;
    assign active_o   = active_q;
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_tick_rr_scheduler.sv
// tb_tick_rr_scheduler
// Directed bench for tick_rr_scheduler.
// Expected grant ids are queued when channels are activated and popped as grants appear.

module tb_tick_rr_scheduler;

    localparam int N_CH        = 4;
    localparam int CNT_MAX     = 104260;
    localparam int CW          = 25;
    localparam int ACK_TIMEOUT = 20;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [N_CH-1:0]   start_stop_i;
    logic              period_load_i;
    logic [CW-1:0]     period_val_i;
    logic [N_CH-1:0]   ack_i;
    logic              ovr_clr_i;
    logic [N_CH-1:0]   grant_o;
    logic [1:0]        grant_id_o;
    logic [N_CH-1:0]   active_o;
    logic              overrun_o;
    logic [N_CH-1:0]   timeout_err_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int expQ[$];
    int g, gPrev, c0;

    tick_rr_scheduler #(
        .N_CH        (N_CH),
        .CNT_MAX     (CNT_MAX),
        .CW          (CW),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_stop_i  (start_stop_i),
        .period_load_i (period_load_i),
        .period_val_i  (period_val_i),
        .ack_i         (ack_i),
        .ovr_clr_i     (ovr_clr_i),
        .grant_o       (grant_o),
        .grant_id_o    (grant_id_o),
        .active_o      (active_o),
        .overrun_o     (overrun_o),
        .timeout_err_o (timeout_err_o)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Count rising edges so grant spacing can be measured.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive every input for exactly one cycle (from a falling edge), then return everything to 0.
    task automatic applyStimulus(input logic [N_CH-1:0] ss, input logic pl, input logic [CW-1:0] pv,
                                 input logic [N_CH-1:0] ak, input logic oc, input logic rs);
        start_stop_i  = ss;
        period_load_i = pl;
        period_val_i  = pv;
        ack_i         = ak;
        ovr_clr_i     = oc;
        rst_i         = rs;
        @(negedge clk);
        start_stop_i  = '0;
        period_load_i = 1'b0;
        period_val_i  = '0;
        ack_i         = '0;
        ovr_clr_i     = 1'b0;
        rst_i         = 1'b0;
    endtask

    task automatic waitGrant(input int bound, output int atCyc);
        int n;
        n = 0;
        while ((grant_o == '0) && (n < bound)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("grantArrived", 32'(grant_o != '0), 32'd1);
        atCyc = cyc;
    endtask

    task automatic checkGrant();
        int e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboardUnderflow: observed grant %0h expected none", grant_o);
        end else begin
            e = expQ.pop_front();
            checkOutput("grantId", 32'(grant_id_o), 32'(e));
            checkOutput("grantOneHot", 32'(grant_o), 32'(1) << e);
        end
    endtask

    task automatic ackGrant(input int id);
        logic [N_CH-1:0] m;
        m = N_CH'(1) << id;
        applyStimulus('0, 1'b0, '0, m, 1'b0, 1'b0);
        checkOutput("ackClears", 32'(grant_o), 32'd0);
    endtask

    initial begin
        int seq[6];
        logic [N_CH-1:0] m;
        seq = '{0, 1, 3, 0, 1, 3};

        rst_i = 1'b1;
        start_stop_i = '0;
        period_load_i = 1'b0;
        period_val_i = '0;
        ack_i = '0;
        ovr_clr_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        $display("[TB] reset values");
        checkOutput("rstGrant", 32'(grant_o), 32'd0);
        checkOutput("rstGrantId", 32'(grant_id_o), 32'd0);
        checkOutput("rstActive", 32'(active_o), 32'd0);
        checkOutput("rstOverrun", 32'(overrun_o), 32'd0);
        checkOutput("rstTimeoutErr", 32'(timeout_err_o), 32'd0);

        $display("[TB] timing and first grant");
        applyStimulus('0, 1'b1, CW'(9), '0, 1'b0, 1'b0);
        c0 = cyc;
        applyStimulus(4'b0001, 1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("t1Active", 32'(active_o), 32'h1);
        expQ.push_back(0);
        expQ.push_back(0);
        waitGrant(40, g);
        checkOutput("t1Latency", 32'(g - c0), 32'd11);
        checkGrant();
        ackGrant(0);
        gPrev = g;
        waitGrant(40, g);
        checkOutput("t1Interval", 32'(g - gPrev), 32'd10);
        checkGrant();
        ackGrant(0);

        $display("[TB] round robin with a gap");
        applyStimulus('0, 1'b0, '0, '0, 1'b0, 1'b1);
        applyStimulus('0, 1'b1, CW'(9), '0, 1'b0, 1'b0);
        applyStimulus(4'b1011, 1'b0, '0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) expQ.push_back(seq[k]);
        for (int k = 0; k < 6; k++) begin
            waitGrant(40, g);
            if (k > 0) checkOutput("rrInterval", 32'(g - gPrev), 32'd10);
            gPrev = g;
            checkGrant();
            m = ~(N_CH'(1) << seq[k]);
            applyStimulus('0, 1'b0, '0, m, 1'b0, 1'b0);
            checkOutput("rrForeignAckIgnored", 32'(grant_o), 32'(1) << seq[k]);
            ackGrant(seq[k]);
        end
        checkOutput("rrNoOverrun", 32'(overrun_o), 32'd0);

        $display("[TB] overrun");
        applyStimulus('0, 1'b0, '0, '0, 1'b0, 1'b1);
        applyStimulus('0, 1'b1, CW'(9), '0, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b0, '0, '0, 1'b0, 1'b0);
        expQ.push_back(0);
        expQ.push_back(0);
        waitGrant(40, g);
        checkGrant();
        repeat (9) @(negedge clk);
        checkOutput("ovrBeforeTick", 32'(overrun_o), 32'd0);
        @(negedge clk);
        checkOutput("ovrAtTick", 32'(overrun_o), 32'd1);
        checkOutput("ovrGrantHeld", 32'(grant_o), 32'h1);
        repeat (4) @(negedge clk);
        ackGrant(0);
        applyStimulus('0, 1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("ovrCleared", 32'(overrun_o), 32'd0);
        gPrev = g;
        waitGrant(40, g);
        checkOutput("ovrNextGrantSpacing", 32'(g - gPrev), 32'd20);
        checkGrant();
        repeat (9) @(negedge clk);
        ovr_clr_i = 1'b1;
        @(negedge clk);
        checkOutput("ovrSetBeatsClear", 32'(overrun_o), 32'd1);
        @(negedge clk);
        checkOutput("ovrClearHeld", 32'(overrun_o), 32'd0);
        ovr_clr_i = 1'b0;
        ackGrant(0);

        $display("[TB] deactivate while granted");
        applyStimulus('0, 1'b0, '0, '0, 1'b0, 1'b1);
        applyStimulus('0, 1'b1, CW'(9), '0, 1'b0, 1'b0);
        applyStimulus(4'b0111, 1'b0, '0, '0, 1'b0, 1'b0);
        expQ.push_back(0);
        expQ.push_back(1);
        expQ.push_back(2);
        waitGrant(40, g);
        checkGrant();
        ackGrant(0);
        waitGrant(40, g);
        checkGrant();
        applyStimulus(4'b0010, 1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("deactGrantDropped", 32'(grant_o), 32'd0);
        checkOutput("deactActive", 32'(active_o), 32'h5);

        $display("[TB] blocked period load and mid-grant reset");
        applyStimulus('0, 1'b1, CW'(3), '0, 1'b0, 1'b0);
        gPrev = g;
        waitGrant(40, g);
        checkOutput("blockedLoadInterval", 32'(g - gPrev), 32'd10);
        checkGrant();
        applyStimulus('0, 1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("midRstGrant", 32'(grant_o), 32'd0);
        checkOutput("midRstGrantId", 32'(grant_id_o), 32'd0);
        checkOutput("midRstActive", 32'(active_o), 32'd0);
        checkOutput("midRstOverrun", 32'(overrun_o), 32'd0);
        applyStimulus('0, 1'b1, CW'(9), '0, 1'b0, 1'b0);
        applyStimulus(4'b1111, 1'b0, '0, '0, 1'b0, 1'b0);
        expQ.push_back(0);
        waitGrant(40, g);
        checkGrant();
        ackGrant(0);

        $display("[TB] ack watchdog");
        applyStimulus('0, 1'b0, '0, '0, 1'b0, 1'b1);
        applyStimulus('0, 1'b1, CW'(9), '0, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b0, '0, '0, 1'b0, 1'b0);
        expQ.push_back(2);
        waitGrant(40, g);
        checkGrant();
        repeat (20) @(negedge clk);
        checkOutput("toGrantStillHeld", 32'(grant_o), 32'h4);
        checkOutput("toErrNotYet", 32'(timeout_err_o), 32'd0);
        @(negedge clk);
`ifdef TICK_RR_SCHED_TIMEOUT_EN
        checkOutput("toGrantDropped", 32'(grant_o), 32'd0);
        checkOutput("toErrSet", 32'(timeout_err_o), 32'h4);
        expQ.push_back(2);
        gPrev = g;
        waitGrant(40, g);
        checkOutput("toRegrantSpacing", 32'(g - gPrev), 32'd30);
        checkGrant();
        ackGrant(2);
        checkOutput("toErrSticky", 32'(timeout_err_o), 32'h4);
`else
        checkOutput("noToGrantHeld", 32'(grant_o), 32'h4);
        checkOutput("noToErrTied", 32'(timeout_err_o), 32'd0);
        ackGrant(2);
`endif

        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_rr_scheduler.md
Name: tick_rr_scheduler

Overview:
- Shares one periodic update-tick timer between N_CH requesters, such as the UART TX framer, the seven-segment refresh and the LED scan.
- Each requester toggles its own participation with a start/stop pulse.
- Each period tick is granted to the next active requester in round-robin order; the grant is held until that requester acknowledges it.
- Sits between the channel controllers and the display/UART datapaths, replacing per-channel free-running counters.

Parameters:
- N_CH, 4, number of requesters (2..8).
- CNT_MAX, 104260, reset value of the period register; a tick occurs every CNT_MAX+1 cycles.
- CW, 25, counter and period width.
- ACK_TIMEOUT, 1023, cycles allowed for an ack (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- start_stop  input  N_CH  per-channel one-cycle toggle pulse.
- period_load  input  1  load period_val into the period register.
- period_val  input  CW  new period value.
- ack  input  N_CH  per-channel acknowledge of the current grant.
- ovr_clr  input  1  clear the overrun flag.
- grant  output  N_CH  one-hot grant, held until ack.
- grant_id  output  $clog2(N_CH)  index of the granted channel; valid while grant!=0.
- active  output  N_CH  current participation mask.
- overrun  output  1  sticky: a tick was dropped.
- timeout_err  output  N_CH  sticky ack-timeout per channel.

Behaviour:
- Reset: clk and rst are the only clock and reset; reset is synchronous and active-high, sampled on the clk rising edge.
  - Reset values: active=0, grant=0, grant_id=0, overrun=0, timeout_err=0.
  - Internal: count=0, period=CNT_MAX, last_id=N_CH-1 (so channel 0 is granted first), state IDLE.
  - Reset mid-grant drops grant on the next edge.
- active[i] toggles on each cycle that start_stop[i]=1.
- Period load:
  - period_load is accepted only when active==0; otherwise it is ignored.
  - period_val=0 is stored as 1.
- Counter:
  - Runs while active!=0; counts 0..period.
  - The internal tick fires when count==period, then count wraps to 0. The period is therefore period+1 cycles.
  - When active==0, count is cleared to 0 every cycle.
- FSM state IDLE:
  - On tick, select the first active channel searching upward from last_id+1 (mod N_CH).
  - The next edge sets grant[sel]=1, grant_id=sel, last_id=sel, state=WAIT_ACK.
  - Grant latency is 1 cycle after the tick.
- FSM state WAIT_ACK:
  - grant stays stable.
  - When ack[grant_id]=1, grant clears on the next edge and the state returns to IDLE.
  - ack bits of non-granted channels are ignored.
- Tick during WAIT_ACK, including the ack cycle: the tick is dropped, overrun is set, and no grant is queued.
- Granted channel deactivated during WAIT_ACK: grant is withdrawn on the next edge and the state returns to IDLE. last_id keeps that channel.
- Simultaneous start_stop on a channel and tick in IDLE: selection uses the pre-toggle active mask.
- overrun: set has priority over ovr_clr in the same cycle.
- Only one grant is ever outstanding; grant is always zero or one-hot.

Optional Feature:
- Macro: TICK_RR_SCHED_TIMEOUT_EN.
- Defined:
  - A wait counter starts at grant assertion.
  - If no ack arrives within ACK_TIMEOUT cycles (counter reaches ACK_TIMEOUT), grant is withdrawn on the next edge and timeout_err[grant_id] is set (sticky until rst). State returns to IDLE.
- Undefined:
  - WAIT_ACK waits indefinitely.
  - timeout_err is tied to 0.

Test Plan:
- Timing and first grant: period_val=9 loaded with active=0, then start_stop[0] pulse.
  - Expect the tick every 10 cycles.
  - Expect grant=0001 one cycle after the first tick.
  - ack[0] held 1 cycle, then grant=0000 on the next edge.
- Round-robin with a gap: channels 0, 1 and 3 active, ack returned 2 cycles after each grant.
  - Expect grant_id sequence 0,1,3,0,1,3.
  - Channel 2 is never granted.
- Overrun: period 9, channel 0 active, ack withheld for 15 cycles.
  - Expect overrun=1 at the second tick, with grant unchanged.
  - ovr_clr then returns overrun to 0.
- Deactivate while granted: start_stop[1] pulse while grant=0010.
  - Expect grant=0000 on the next edge.
  - The next tick grants the next active channel after 1.
- Blocked load and mid-grant reset:
  - period_load with active!=0: period unchanged, tick interval unchanged.
  - rst asserted while grant is pending: all outputs are 0 on the next edge, and the next grant after restart goes to channel 0.
- With TICK_RR_SCHED_TIMEOUT_EN and ACK_TIMEOUT=20: ack never returned for channel 2.
  - grant drops 21 cycles after assertion.
  - timeout_err=0100.
